// File: rtl/membus_2_arbiter.sv
// membus_2_arbiter: grants one memory bus to one of two masters per memory cycle, with NXM timeout.
module membus_2_arbiter #(
  parameter bit RR      = 1'b1,
  parameter int TIMEOUT = 1000,
  parameter int TO_W    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_rq_cyc,
  input  logic        m0_rd_rq,
  input  logic        m0_wr_rq,
  input  logic        m0_wr_rs,
  input  logic        m0_fmc_select,
  input  logic [14:0] m0_ma,
  input  logic [3:0]  m0_sel,
  input  logic [35:0] m0_mb_write,
  output logic        m0_addr_ack,
  output logic        m0_rd_rs,
  output logic [35:0] m0_mb_read,
  output logic        m0_nxm,
  input  logic        m1_rq_cyc,
  input  logic        m1_rd_rq,
  input  logic        m1_wr_rq,
  input  logic        m1_wr_rs,
  input  logic        m1_fmc_select,
  input  logic [14:0] m1_ma,
  input  logic [3:0]  m1_sel,
  input  logic [35:0] m1_mb_write,
  output logic        m1_addr_ack,
  output logic        m1_rd_rs,
  output logic [35:0] m1_mb_read,
  output logic        m1_nxm,
  output logic        s_rq_cyc,
  output logic        s_rd_rq,
  output logic        s_wr_rq,
  output logic        s_wr_rs,
  output logic        s_fmc_select,
  output logic [14:0] s_ma,
  output logic [3:0]  s_sel,
  output logic [35:0] s_mb_write,
  input  logic        s_addr_ack,
  input  logic        s_rd_rs,
  input  logic [35:0] s_mb_read,
  output logic        busy,
  output logic        owner
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, WAIT_LOW, NXM} state_t;
  state_t state, state_nx;
  logic owner_nx, last, last_nx, is_wr, is_wr_nx;
  logic [TO_W-1:0] timer, timer_nx;
  logic fwd, o_rq_cyc, o_wr_rq, o_wr_rs, done, expired, grant;
  assign fwd      = state == ADDR || state == DATA || state == WAIT_LOW;
  assign o_rq_cyc = owner ? m1_rq_cyc : m0_rq_cyc;
  assign o_wr_rq  = owner ? m1_wr_rq : m0_wr_rq;
  assign o_wr_rs  = owner ? m1_wr_rs : m0_wr_rs;
  // writes and read-modify-writes finish on the master's wr_rs, plain reads on the slave's rd_rs
  assign done     = is_wr ? o_wr_rs : s_rd_rs;
  assign expired  = timer == TO_W'(TIMEOUT - 1);
  assign grant    = (m0_rq_cyc && m1_rq_cyc) ? (RR ? ~last : 1'b0) : m1_rq_cyc;
  assign busy     = state != IDLE;
  assign s_rq_cyc     = fwd && o_rq_cyc;
  assign s_rd_rq      = fwd && (owner ? m1_rd_rq : m0_rd_rq);
  assign s_wr_rq      = fwd && o_wr_rq;
  assign s_wr_rs      = fwd && o_wr_rs;
  assign s_fmc_select = fwd && (owner ? m1_fmc_select : m0_fmc_select);
  assign s_ma         = fwd ? (owner ? m1_ma : m0_ma) : '0;
  assign s_sel        = fwd ? (owner ? m1_sel : m0_sel) : '0;
  assign s_mb_write   = fwd ? (owner ? m1_mb_write : m0_mb_write) : '0;
  assign m0_addr_ack  = fwd && !owner && s_addr_ack;
  assign m1_addr_ack  = fwd && owner && s_addr_ack;
  assign m0_rd_rs     = fwd && !owner && s_rd_rs;
  assign m1_rd_rs     = fwd && owner && s_rd_rs;
  assign m0_mb_read   = (fwd && !owner) ? s_mb_read : '0;
  assign m1_mb_read   = (fwd && owner) ? s_mb_read : '0;
  assign m0_nxm       = state == NXM && !owner;
  assign m1_nxm       = state == NXM && owner;
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    is_wr_nx = is_wr;
    timer_nx = timer;
    case (state)
      IDLE: if (m0_rq_cyc || m1_rq_cyc) begin
        state_nx = ADDR;
        owner_nx = grant;
        timer_nx = '0;
      end
      ADDR: if (s_addr_ack) begin
        state_nx = DATA;
        is_wr_nx = o_wr_rq;
        timer_nx = '0;
      end else if (!o_rq_cyc) state_nx = IDLE;
      else if (expired) state_nx = NXM;
      else timer_nx = timer + 1'b1;
      DATA: if (done) state_nx = WAIT_LOW;
      else if (expired) state_nx = NXM;
      else timer_nx = timer + 1'b1;
      WAIT_LOW: if (!done && !o_rq_cyc) begin
        state_nx = IDLE;
        last_nx  = owner;
      end
      NXM: begin
        state_nx = IDLE;
        last_nx  = owner;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      is_wr <= 1'b0;
      timer <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      last  <= last_nx;
      is_wr <= is_wr_nx;
      timer <= timer_nx;
    end
  end
endmodule

// File: tb/tb_membus_2_arbiter.sv
// tb_membus_2_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_membus_2_arbiter;
  localparam int TO = 16;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] rq, rdq, wrq, wrs, fmc;
  logic [14:0] ma[2];
  logic [3:0] sel[2];
  logic [35:0] mbw[2];
  logic s_ack, s_rdrs;
  logic [35:0] s_mbr;
  logic aack0[2], aack1[2], rrs0[2], rrs1[2], nxm0[2], nxm1[2];
  logic s_rc[2], s_rr[2], s_wr[2], s_ws[2], s_fm[2], busy[2], own[2];
  logic [35:0] mbr0[2], mbr1[2], s_mw[2];
  logic [14:0] s_ma[2];
  logic [3:0] s_sl[2];
  int errors = 0, checks = 0;

  membus_2_arbiter #(.RR(1'b1), .TIMEOUT(TO), .TO_W(5)) u_rr (
    .clk(clk), .reset(reset),
    .m0_rq_cyc(rq[0]), .m0_rd_rq(rdq[0]), .m0_wr_rq(wrq[0]), .m0_wr_rs(wrs[0]), .m0_fmc_select(fmc[0]),
    .m0_ma(ma[0]), .m0_sel(sel[0]), .m0_mb_write(mbw[0]),
    .m0_addr_ack(aack0[0]), .m0_rd_rs(rrs0[0]), .m0_mb_read(mbr0[0]), .m0_nxm(nxm0[0]),
    .m1_rq_cyc(rq[1]), .m1_rd_rq(rdq[1]), .m1_wr_rq(wrq[1]), .m1_wr_rs(wrs[1]), .m1_fmc_select(fmc[1]),
    .m1_ma(ma[1]), .m1_sel(sel[1]), .m1_mb_write(mbw[1]),
    .m1_addr_ack(aack1[0]), .m1_rd_rs(rrs1[0]), .m1_mb_read(mbr1[0]), .m1_nxm(nxm1[0]),
    .s_rq_cyc(s_rc[0]), .s_rd_rq(s_rr[0]), .s_wr_rq(s_wr[0]), .s_wr_rs(s_ws[0]), .s_fmc_select(s_fm[0]),
    .s_ma(s_ma[0]), .s_sel(s_sl[0]), .s_mb_write(s_mw[0]),
    .s_addr_ack(s_ack), .s_rd_rs(s_rdrs), .s_mb_read(s_mbr),
    .busy(busy[0]), .owner(own[0]));

  membus_2_arbiter #(.RR(1'b0), .TIMEOUT(TO), .TO_W(5)) u_fp (
    .clk(clk), .reset(reset),
    .m0_rq_cyc(rq[0]), .m0_rd_rq(rdq[0]), .m0_wr_rq(wrq[0]), .m0_wr_rs(wrs[0]), .m0_fmc_select(fmc[0]),
    .m0_ma(ma[0]), .m0_sel(sel[0]), .m0_mb_write(mbw[0]),
    .m0_addr_ack(aack0[1]), .m0_rd_rs(rrs0[1]), .m0_mb_read(mbr0[1]), .m0_nxm(nxm0[1]),
    .m1_rq_cyc(rq[1]), .m1_rd_rq(rdq[1]), .m1_wr_rq(wrq[1]), .m1_wr_rs(wrs[1]), .m1_fmc_select(fmc[1]),
    .m1_ma(ma[1]), .m1_sel(sel[1]), .m1_mb_write(mbw[1]),
    .m1_addr_ack(aack1[1]), .m1_rd_rs(rrs1[1]), .m1_mb_read(mbr1[1]), .m1_nxm(nxm1[1]),
    .s_rq_cyc(s_rc[1]), .s_rd_rq(s_rr[1]), .s_wr_rq(s_wr[1]), .s_wr_rs(s_ws[1]), .s_fmc_select(s_fm[1]),
    .s_ma(s_ma[1]), .s_sel(s_sl[1]), .s_mb_write(s_mw[1]),
    .s_addr_ack(s_ack), .s_rd_rs(s_rdrs), .s_mb_read(s_mbr),
    .busy(busy[1]), .owner(own[1]));

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rq = '0; rdq = '0; wrq = '0; wrs = '0; fmc = '0;
    ma = '{15'd0, 15'd0}; sel = '{4'd0, 4'd0}; mbw = '{36'd0, 36'd0};
    s_ack = 1'b0; s_rdrs = 1'b0; s_mbr = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    #2 reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    rq = 2'b11; rdq = 2'b11; ma = '{15'o7777, 15'o1234}; s_ack = 1'b1; s_rdrs = 1'b1; s_mbr = 36'o123;
    #3;
    checks++;
    if ({busy[0], own[0], s_rc[0], s_rr[0], aack0[0], aack1[0], rrs0[0], nxm0[0], nxm1[0]} !== 9'd0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0", {busy[0], own[0], s_rc[0], s_rr[0], aack0[0], aack1[0], rrs0[0], nxm0[0], nxm1[0]});
    end
    @(posedge clk); #1;
    checks++;
    if ({s_ma[0], mbr0[0], mbr1[0], busy[0]} !== '0) begin
      errors++; $display("FAIL reset_held: got ma=%o mbr0=%o busy=%b want 0", s_ma[0], mbr0[0], busy[0]);
    end
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    rq[0] = 1'b1; rdq[0] = 1'b1; ma[0] = 15'o01234; sel[0] = 4'h3;
    #1;
    checks++;
    if (busy[0] !== 1'b0 || s_ma[0] !== 15'd0) begin
      errors++; $display("FAIL rd_sample: got busy=%b ma=%o want 0 0", busy[0], s_ma[0]);
    end
    tick();
    checks++;
    if ({busy[0], own[0], s_rc[0], s_rr[0], s_wr[0], s_ma[0], s_sl[0]} !== {5'b10110, 15'o01234, 4'h3}) begin
      errors++; $display("FAIL rd_fwd: got b=%b o=%b rc=%b rr=%b wr=%b ma=%o sel=%h", busy[0], own[0], s_rc[0], s_rr[0], s_wr[0], s_ma[0], s_sl[0]);
    end
    tick();
    s_ack = 1'b1; #1;
    checks++;
    if (aack0[0] !== 1'b1 || aack1[0] !== 1'b0) begin
      errors++; $display("FAIL rd_ack: got m0=%b m1=%b want 1 0", aack0[0], aack1[0]);
    end
    tick();
    s_ack = 1'b0; s_rdrs = 1'b1; s_mbr = 36'o123456701234; #1;
    checks++;
    if (mbr0[0] !== 36'o123456701234 || mbr1[0] !== 36'd0 || rrs0[0] !== 1'b1 || rrs1[0] !== 1'b0) begin
      errors++; $display("FAIL rd_data: got m0=%o m1=%o rs0=%b rs1=%b", mbr0[0], mbr1[0], rrs0[0], rrs1[0]);
    end
    tick();
    s_rdrs = 1'b0; s_mbr = '0; rq[0] = 1'b0; rdq[0] = 1'b0; #1;
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++; $display("FAIL rd_hold: got busy=%b want 1", busy[0]);
    end
    tick();
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++; $display("FAIL rd_release: got busy=%b want 0", busy[0]);
    end
  endtask

  task automatic test_contention(input int k);
    int e;
    do_reset();
    rq = 2'b11; rdq = 2'b11;
    for (int r = 0; r < 3; r++) begin
      e = (k == 0) ? r % 2 : 0;
      #1;
      checks++;
      if (busy[k] !== 1'b0) begin
        errors++; $display("FAIL cont%0d_idle%0d: got busy=%b want 0", k, r, busy[k]);
      end
      tick();
      checks++;
      if (busy[k] !== 1'b1 || own[k] !== e[0]) begin
        errors++; $display("FAIL cont%0d_grant%0d: got busy=%b owner=%b want 1 %0d", k, r, busy[k], own[k], e);
      end
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0; s_rdrs = 1'b1;
      tick();
      s_rdrs = 1'b0; rq[e] = 1'b0;
      tick();
      rq[e] = 1'b1;
    end
    clear_inputs();
  endtask

  task automatic test_rmw();
    do_reset();
    rq[1] = 1'b1; rdq[1] = 1'b1; wrq[1] = 1'b1;
    tick();
    checks++;
    if (own[0] !== 1'b1 || s_wr[0] !== 1'b1 || s_rr[0] !== 1'b1) begin
      errors++; $display("FAIL rmw_grant: got owner=%b wr=%b rd=%b want 1 1 1", own[0], s_wr[0], s_rr[0]);
    end
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0; s_rdrs = 1'b1; s_mbr = 36'o555000111222; #1;
    checks++;
    if (mbr1[0] !== 36'o555000111222 || mbr0[0] !== 36'd0) begin
      errors++; $display("FAIL rmw_read: got m1=%o m0=%o", mbr1[0], mbr0[0]);
    end
    tick();
    s_rdrs = 1'b0; s_mbr = '0; rq[1] = 1'b0;
    tick();
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++; $display("FAIL rmw_stay_data: got busy=%b want 1", busy[0]);
    end
    rq[1] = 1'b1; wrs[1] = 1'b1; mbw[1] = 36'o777777000000; #1;
    checks++;
    if (s_mw[0] !== 36'o777777000000 || s_ws[0] !== 1'b1) begin
      errors++; $display("FAIL rmw_write: got data=%o wr_rs=%b", s_mw[0], s_ws[0]);
    end
    tick();
    rq[1] = 1'b0;
    tick();
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++; $display("FAIL rmw_hold_wrrs: got busy=%b want 1", busy[0]);
    end
    wrs[1] = 1'b0;
    tick();
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++; $display("FAIL rmw_release: got busy=%b want 0", busy[0]);
    end
    clear_inputs();
  endtask

  task automatic test_nxm();
    int seen = -1;
    do_reset();
    rq[0] = 1'b1; rdq[0] = 1'b1;
    tick();
    for (int i = 1; i <= 40 && seen < 0; i++) begin
      tick();
      if (nxm0[0] === 1'b1) seen = i;
    end
    checks++;
    if (seen != TO || nxm1[0] !== 1'b0) begin
      errors++; $display("FAIL nxm_time: got pulse at %0d nxm1=%b want %0d 0", seen, nxm1[0], TO);
    end
    rq = 2'b10;
    tick();
    checks++;
    if (nxm0[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL nxm_width: got nxm=%b busy=%b want 0 0", nxm0[0], busy[0]);
    end
    tick();
    checks++;
    if (busy[0] !== 1'b1 || own[0] !== 1'b1) begin
      errors++; $display("FAIL nxm_regrant: got busy=%b owner=%b want 1 1", busy[0], own[0]);
    end
    clear_inputs();
  endtask

  task automatic test_abort_reset();
    do_reset();
    rq[0] = 1'b1;
    tick();
    rq[0] = 1'b0;
    tick();
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got busy=%b want 0", busy[0]);
    end
    rq = 2'b11;
    tick();
    checks++;
    if (own[0] !== 1'b0 || busy[0] !== 1'b1) begin
      errors++; $display("FAIL abort_last: got owner=%b busy=%b want 0 1", own[0], busy[0]);
    end
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0; s_mbr = 36'o1; #1;
    checks++;
    if (mbr0[0] !== 36'o1) begin
      errors++; $display("FAIL areset_pre: got m0 read=%o want 1", mbr0[0]);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy[0], own[0], s_rc[0], s_ma[0], mbr0[0]} !== '0) begin
      errors++; $display("FAIL areset_async: got busy=%b owner=%b rc=%b ma=%o read=%o", busy[0], own[0], s_rc[0], s_ma[0], mbr0[0]);
    end
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
  endtask

  task automatic test_collision();
    int pulses = 0;
    do_reset();
    rq[0] = 1'b1; rdq[0] = 1'b1;
    tick();
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      if (nxm0[0] === 1'b1) pulses++;
    end
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    checks++;
    if (nxm0[0] !== 1'b0 || busy[0] !== 1'b1) begin
      errors++; $display("FAIL coll_ack: got nxm=%b busy=%b want 0 1", nxm0[0], busy[0]);
    end
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      if (nxm0[0] === 1'b1) pulses++;
    end
    s_rdrs = 1'b1;
    tick();
    checks++;
    if (nxm0[0] !== 1'b0 || busy[0] !== 1'b1 || pulses != 0) begin
      errors++; $display("FAIL coll_done: got nxm=%b busy=%b pulses=%0d want 0 1 0", nxm0[0], busy[0], pulses);
    end
    s_rdrs = 1'b0; rq[0] = 1'b0;
    tick();
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++; $display("FAIL coll_release: got busy=%b want 0", busy[0]);
    end
    clear_inputs();
  endtask

  // model phases: 0 idle, 1 waiting for address ack, 2 waiting for completion, 3 waiting for strobes low, 4 nxm
  task automatic test_random();
    int ph[2], start[2];
    bit mo[2], ml[2], mw[2];
    logic [59:0] ef, gf;
    logic [75:0] eb, gb;
    bit fw, e0, e1, dn, quiet;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; start[k] = 0; mo[k] = 0; ml[k] = 1; mw[k] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        rq[n] = rq[n] ^ ($urandom_range(0, 19) == 0);
        rdq[n] = 1'($urandom); wrq[n] = 1'($urandom); fmc[n] = 1'($urandom);
        wrs[n] = ($urandom_range(0, 3) == 0);
        ma[n] = 15'($urandom); sel[n] = 4'($urandom); mbw[n] = {4'($urandom), $urandom};
      end
      quiet = ((cyc / 150) % 3) == 2;
      s_ack = !quiet && ($urandom_range(0, 5) == 0);
      s_rdrs = ($urandom_range(0, 3) == 0);
      s_mbr = {4'($urandom), $urandom};
      #1;
      for (int k = 0; k < 2; k++) begin
        fw = ph[k] >= 1 && ph[k] <= 3;
        e1 = fw && mo[k];
        e0 = fw && !mo[k];
        checks++;
        if (busy[k] !== (ph[k] != 0) || {nxm1[k], nxm0[k]} !== {ph[k] == 4 && mo[k], ph[k] == 4 && !mo[k]}) begin
          errors++; $display("FAIL rnd%0d_state cyc %0d: got busy=%b nxm=%b%b want phase %0d owner %b", k, cyc, busy[k], nxm1[k], nxm0[k], ph[k], mo[k]);
        end
        if (ph[k] != 0) begin
          checks++;
          if (own[k] !== mo[k]) begin
            errors++; $display("FAIL rnd%0d_owner cyc %0d: got %b want %b", k, cyc, own[k], mo[k]);
          end
        end
        ef = fw ? {rq[mo[k]], rdq[mo[k]], wrq[mo[k]], wrs[mo[k]], fmc[mo[k]], ma[mo[k]], sel[mo[k]], mbw[mo[k]]} : '0;
        gf = {s_rc[k], s_rr[k], s_wr[k], s_ws[k], s_fm[k], s_ma[k], s_sl[k], s_mw[k]};
        checks++;
        if (gf !== ef) begin
          errors++; $display("FAIL rnd%0d_fwd cyc %0d: got %h want %h", k, cyc, gf, ef);
        end
        eb = {e1 && s_ack, e0 && s_ack, e1 && s_rdrs, e0 && s_rdrs, e1 ? s_mbr : 36'd0, e0 ? s_mbr : 36'd0};
        gb = {aack1[k], aack0[k], rrs1[k], rrs0[k], mbr1[k], mbr0[k]};
        checks++;
        if (gb !== eb) begin
          errors++; $display("FAIL rnd%0d_back cyc %0d: got %h want %h", k, cyc, gb, eb);
        end
        dn = mw[k] ? wrs[mo[k]] : s_rdrs;
        if (ph[k] == 0) begin
          if (rq != 2'b00) begin
            mo[k] = (rq == 2'b11) ? ((k == 0) ? !ml[k] : 1'b0) : rq[1];
            ph[k] = 1; start[k] = cyc + 1;
          end
        end else if (ph[k] == 1) begin
          if (s_ack) begin
            mw[k] = wrq[mo[k]]; ph[k] = 2; start[k] = cyc + 1;
          end else if (!rq[mo[k]]) ph[k] = 0;
          else if (cyc - start[k] == TO - 1) ph[k] = 4;
        end else if (ph[k] == 2) begin
          if (dn) ph[k] = 3;
          else if (cyc - start[k] == TO - 1) ph[k] = 4;
        end else if (ph[k] == 3) begin
          if (!dn && !rq[mo[k]]) begin
            ph[k] = 0; ml[k] = mo[k];
          end
        end else begin
          ph[k] = 0; ml[k] = mo[k];
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention(0);
    test_contention(1);
    test_rmw();
    test_nxm();
    test_abort_reset();
    test_collision();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
